// File: rtl/mem_pkg.sv
// Shared opcode fields, access-size codes, load-tracking entry and byte-lane helpers for mem_stage_p.
// Latency: none; declarations and pure functions only.
// Backpressure: none; nothing here holds state.
package mem_pkg;

  localparam int OPE_W       = 6;
  localparam int OPE_LD_BIT  = 3;   // 1 = load, 0 = store (when opcode is non-zero)
  localparam int OPE_UNS_BIT = 2;   // 1 = zero-extend a load result
  localparam int TRK_DD_W    = 8;   // widest destination index a tracking entry can carry

  localparam logic [OPE_W-1:0] OP_NOP   = 6'b000000;
  localparam logic [OPE_W-1:0] OP_ST_W  = 6'b000100;
  localparam logic [OPE_W-1:0] OP_ST_H  = 6'b000001;
  localparam logic [OPE_W-1:0] OP_ST_B  = 6'b000010;
  localparam logic [OPE_W-1:0] OP_LD_W  = 6'b001000;
  localparam logic [OPE_W-1:0] OP_LD_H  = 6'b001001;
  localparam logic [OPE_W-1:0] OP_LD_B  = 6'b001010;
  localparam logic [OPE_W-1:0] OP_LD_HU = 6'b001101;
  localparam logic [OPE_W-1:0] OP_LD_BU = 6'b001110;

  typedef enum logic [1:0] {
    SZ_W = 2'b00,
    SZ_H = 2'b01,
    SZ_B = 2'b10,
    SZ_R = 2'b11
  } size_e;

  // One in-flight load, carried alongside the RAM read pipe.
  typedef struct packed {
    logic                vld;
    logic [TRK_DD_W-1:0] dd;
    size_e               size;
    logic                uns;
    logic [1:0]          off;
  } trk_t;

  // Drop the offset bits that the access size does not allow.
  function automatic logic [1:0] align_off(size_e size, logic [1:0] off);
    case (size)
      SZ_W:    align_off = 2'b00;
      SZ_H:    align_off = {off[1], 1'b0};
      default: align_off = off;
    endcase
  endfunction

  function automatic logic misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_W:    misaligned = (off != 2'b00);
      SZ_H:    misaligned = off[0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Byte-lane write enables for an already aligned offset.
  function automatic logic [3:0] lane_we(size_e size, logic [1:0] off);
    case (size)
      SZ_W:    lane_we = 4'b1111;
      SZ_H:    lane_we = off[1] ? 4'b1100 : 4'b0011;
      SZ_B:    lane_we = 4'b0001 << off;
      default: lane_we = 4'b0000;
    endcase
  endfunction

  // Pick the byte/half at off out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(logic [31:0] word, size_e size,
                                               logic [1:0] off, logic uns);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? word[31:16] : word[15:0];
    b = word[{off, 3'b000} +: 8];
    case (size)
      SZ_H:    load_extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      SZ_B:    load_extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half from returning RAM data and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; follows the read data every cycle.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        uns,
  output logic [31:0] data
);

  // Lane select and extension for the result register.
  always_comb begin
    data = load_extract(word, size, off, uns);
  end

endmodule

// File: rtl/mem_stage_p.sv
// Data-memory access stage: byte/half/word loads and stores with lane enables; macro MEM_MISALIGN_EXC_EN adds misalign flagging.
// Latency: RAM request 1 cycle after input; load write-back RD_LAT+2 cycles after input.
// Backpressure: none; one operation accepted every cycle, never stalls.
module mem_stage_p
  import mem_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32,
  parameter int REG_W  = 6,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OPE_W-1:0]  ope,
  input  logic [DATA_W-1:0] ds_val,
  input  logic [DATA_W-1:0] dt_val,
  input  logic [REG_W-1:0]  dd,
  input  logic [15:0]       imm,
  output logic [REG_W-1:0]  reg_addr,
  output logic [DATA_W-1:0] reg_dd_val,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] d_rdata,
  output logic              d_en,
  output logic [3:0]        d_we
`ifdef MEM_MISALIGN_EXC_EN
  ,
  output logic              misalign
`endif
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_stage_p: DATA_W must be 32");
  end
  if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
    $error("mem_stage_p: RD_LAT must be 1..8");
  end
  if (REG_W > TRK_DD_W) begin : g_bad_reg_w
    $error("mem_stage_p: REG_W exceeds tracking entry width");
  end

  logic [31:0] ea;
  size_e       size;
  logic [1:0]  aoff;
  logic        is_op, is_ld, is_st;
  logic [3:0]  we_c;
  logic [31:0] wdata_c;
  trk_t        ent_c;
`ifdef MEM_MISALIGN_EXC_EN
  logic        mis_c;
`endif

  trk_t        s1_ent;
  trk_t        trk [RD_LAT];
  trk_t        trk_out;
  logic [31:0] ld_data;
  logic        unused_bits;

  // Decode the incoming operation into the RAM request and its tracking entry.
  always_comb begin
    ea      = ds_val + {{16{imm[15]}}, imm};
    size    = size_e'(ope[1:0]);
    is_op   = in_valid && (ope != OP_NOP) && (size != SZ_R);
    is_ld   = is_op && ope[OPE_LD_BIT];
    is_st   = is_op && !ope[OPE_LD_BIT];
    aoff    = align_off(size, ea[1:0]);
    we_c    = is_st ? lane_we(size, aoff) : 4'b0000;
    case (size)
      SZ_B:    wdata_c = {4{dt_val[7:0]}};
      SZ_H:    wdata_c = {2{dt_val[15:0]}};
      default: wdata_c = dt_val;
    endcase
    ent_c      = '0;
    ent_c.vld  = is_ld;
    ent_c.dd   = TRK_DD_W'(dd);
    ent_c.size = size;
    ent_c.uns  = ope[OPE_UNS_BIT];
    ent_c.off  = aoff;
`ifdef MEM_MISALIGN_EXC_EN
    // A misaligned access is flagged and neither writes memory nor writes back.
    mis_c = (is_ld || is_st) && misaligned(size, ea[1:0]);
    if (mis_c) begin
      we_c      = 4'b0000;
      ent_c.vld = 1'b0;
    end
`endif
  end

  // S1: register the RAM request and hand the entry to the tracking pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_addr  <= '0;
      d_wdata <= '0;
      d_we    <= '0;
      d_en    <= 1'b0;
      s1_ent  <= '0;
    end else begin
      d_addr  <= ea[ADDR_W+1:2];
      d_wdata <= wdata_c;
      d_we    <= we_c;
      d_en    <= 1'b1;
      s1_ent  <= ent_c;
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  // Misalign flag pulses alongside the S1 request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= mis_c;
  end
`endif

  // Tracking pipe: entry reaches the tail in the cycle its RAM data is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) trk[i] <= '0;
    end else begin
      trk[0] <= s1_ent;
      for (int i = 1; i < RD_LAT; i++) trk[i] <= trk[i-1];
    end
  end

  assign trk_out     = trk[RD_LAT-1];
  assign unused_bits = ^{ea, trk_out.dd};

  mem_load_align u_align (
    .word (d_rdata),
    .size (trk_out.size),
    .off  (trk_out.off),
    .uns  (trk_out.uns),
    .data (ld_data)
  );

  // Write-back register: load result or an explicit "no write" slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_addr   <= '0;
      reg_dd_val <= '0;
    end else if (trk_out.vld) begin
      reg_addr   <= trk_out.dd[REG_W-1:0];
      reg_dd_val <= ld_data;
    end else begin
      reg_addr   <= '0;
      reg_dd_val <= '0;
    end
  end

endmodule
